// File: rtl/tamarac_trace_pkg.sv
// Shared constants, state encoding and character helpers for the tamarac trace UART.
package tamarac_trace_pkg;

    localparam int LINE_LEN = 17;

    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_M  = 8'h4D;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} trace_state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] acc;
        logic [7:0]  mpc;
    } snap_t;

    function automatic logic [7:0] hex2ascii(input logic [3:0] n);
        logic [7:0] r;
        r = (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
        return r;
    endfunction

    // Character at position idx of "Pxxxx Axxxx Mxx\r\n" for a given snapshot.
    function automatic logic [7:0] line_char(input logic [4:0] idx, input snap_t s);
        logic [7:0] c;
        case (idx)
            5'd0:    c = CH_P;
            5'd1:    c = hex2ascii(s.pc[15:12]);
            5'd2:    c = hex2ascii(s.pc[11:8]);
            5'd3:    c = hex2ascii(s.pc[7:4]);
            5'd4:    c = hex2ascii(s.pc[3:0]);
            5'd5:    c = CH_SP;
            5'd6:    c = CH_A;
            5'd7:    c = hex2ascii(s.acc[15:12]);
            5'd8:    c = hex2ascii(s.acc[11:8]);
            5'd9:    c = hex2ascii(s.acc[7:4]);
            5'd10:   c = hex2ascii(s.acc[3:0]);
            5'd11:   c = CH_SP;
            5'd12:   c = CH_M;
            5'd13:   c = hex2ascii(s.mpc[7:4]);
            5'd14:   c = hex2ascii(s.mpc[3:0]);
            5'd15:   c = CH_CR;
            default: c = CH_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; a byte offered while the stop bit ends is started
// on the very next bit slot, so characters run back-to-back.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd,
    output logic       active,
    output logic       done
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    logic [7:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic          bit_end;

    assign bit_end = active && (baud_cnt == BAUD_MAX);
    assign done    = bit_end && (bit_cnt == 4'd9);
    assign ready   = !active || done;

    // bit_cnt: 0 = start, 1..8 = data LSB first, 9 = stop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active   <= 1'b0;
            txd      <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else if (valid && ready) begin
            active   <= 1'b1;
            txd      <= 1'b0;
            shreg    <= data;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else if (done) begin
            active   <= 1'b0;
            txd      <= 1'b1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd8) begin
                txd <= 1'b1;
            end else begin
                txd   <= shreg[0];
                shreg <= {1'b0, shreg[7:1]};
            end
        end else if (active) begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/trace_uart_tx.sv
// Trace line sender: snapshots PC/ACC/MPC on start and emits one ASCII line
// through uart_tx_byte; starts arriving mid-line are counted in dropped.
module trace_uart_tx
    import tamarac_trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [12:0] pc,
    input  logic [15:0] acc,
    input  logic [4:0]  mpc,
    output logic        txd,
    output logic        busy,
    output logic [7:0]  dropped
);

    localparam logic [4:0] LAST_IDX = 5'(LINE_LEN - 1);

    trace_state_e state, state_nxt;
    snap_t        snap;
    logic [4:0]   idx;
    logic         last_sent;
    logic         accept;
    logic         tx_valid, tx_ready, tx_done, tx_active;
    logic [7:0]   tx_data;

    assign accept = start && (state == IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SEND;
            SEND:    if (last_sent && tx_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (state == SEND) && !last_sent;
        tx_data  = line_char(idx, snap);
    end

    // idx names the next character to hand over; last_sent marks LF handed over.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap      <= '0;
            idx       <= '0;
            last_sent <= 1'b0;
            dropped   <= '0;
        end else begin
            if (accept) begin
                snap.pc   <= {3'b000, pc};
                snap.acc  <= acc;
                snap.mpc  <= {3'b000, mpc};
                idx       <= '0;
                last_sent <= 1'b0;
            end else if (tx_valid && tx_ready) begin
                if (idx == LAST_IDX) last_sent <= 1'b1;
                else                 idx       <= idx + 5'd1;
            end
            if (start && (state != IDLE) && (dropped != 8'hFF))
                dropped <= dropped + 8'd1;
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clock  (clock),
        .reset  (reset),
        .valid  (tx_valid),
        .data   (tx_data),
        .ready  (tx_ready),
        .txd    (txd),
        .active (tx_active),
        .done   (tx_done)
    );

    // The engine is active exactly from the first start bit to the end of the LF stop bit.
    assign busy = tx_active;

endmodule

// File: tb/tb_trace_uart_tx.sv
// Randomized bench for trace_uart_tx against a character/bit-level line model.
module tb_trace_uart_tx;

    localparam int CPB      = 4;
    localparam int LINE_CYC = 170 * CPB;

    typedef logic [7:0] line_t [17];

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [12:0] pc    = '0;
    logic [15:0] acc   = '0;
    logic [4:0]  mpc   = '0;
    logic        txd, busy;
    logic [7:0]  dropped;

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   drop_model = 0;
    logic cap_txd  [LINE_CYC];
    logic cap_busy [LINE_CYC];
    logic lat_ok, end_ok;

    trace_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .start(start), .pc(pc), .acc(acc),
        .mpc(mpc), .txd(txd), .busy(busy), .dropped(dropped)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] hexch(int v);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction

    function automatic line_t model_line(logic [12:0] p, logic [15:0] a, logic [4:0] m);
        line_t l;
        int pv = int'(p);
        int av = int'(a);
        int mv = int'(m);
        l[0] = "P";
        for (int i = 0; i < 4; i++) l[1 + i] = hexch((pv >> (12 - 4 * i)) & 15);
        l[5] = " ";
        l[6] = "A";
        for (int i = 0; i < 4; i++) l[7 + i] = hexch((av >> (12 - 4 * i)) & 15);
        l[11] = " ";
        l[12] = "M";
        l[13] = hexch((mv >> 4) & 15);
        l[14] = hexch(mv & 15);
        l[15] = 8'd13;
        l[16] = 8'd10;
        return l;
    endfunction

    function automatic string line_txt(line_t l);
        string s = "";
        for (int i = 0; i < 17; i++) begin
            if (l[i] == 8'd13)      s = {s, "<CR>"};
            else if (l[i] == 8'd10) s = {s, "<LF>"};
            else                    s = $sformatf("%s%c", s, l[i]);
        end
        return s;
    endfunction

    // Host-side view: sample each data bit in the middle of its slot.
    function automatic line_t cap_line();
        line_t l;
        for (int c = 0; c < 17; c++)
            for (int b = 0; b < 8; b++)
                l[c][b] = cap_txd[c * 10 * CPB + (b + 1) * CPB + CPB / 2];
        return l;
    endfunction

    // Number of captured cycles that differ from an ideal back-to-back 8N1 waveform.
    function automatic int wave_errors(line_t l);
        int   e = 0;
        logic want;
        for (int c = 0; c < 17; c++)
            for (int b = 0; b < 10; b++)
                for (int t = 0; t < CPB; t++) begin
                    want = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : l[c][b - 1];
                    if (cap_txd[c * 10 * CPB + b * CPB + t] !== want) e++;
                end
        return e;
    endfunction

    function automatic int busy_errors();
        int e = 0;
        for (int k = 0; k < LINE_CYC; k++) if (cap_busy[k] !== 1'b1) e++;
        return e;
    endfunction

    task automatic randomize_inputs();
        pc  = 13'($urandom);
        acc = 16'($urandom);
        mpc = 5'($urandom);
    endtask

    // Called at a negedge: pulse start, capture one full line, then look one cycle past its end.
    task automatic run_line(input logic [12:0] p, input logic [15:0] a, input logic [4:0] m,
                            input bit mutate, input bit spam, input bit tail);
        pc = p; acc = a; mpc = m; start = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        lat_ok = (busy === 1'b0) && (txd === 1'b1);
        if (mutate) randomize_inputs();
        for (int k = 0; k < LINE_CYC; k++) begin
            @(negedge clock);
            cap_txd[k]  = txd;
            cap_busy[k] = busy;
            if (mutate) randomize_inputs();
            start = (spam && k >= 10 && k < 310) || (tail && k == LINE_CYC - 1);
            if (start && drop_model < 255) drop_model++;
        end
        @(negedge clock);
        start  = 1'b0;
        end_ok = (busy === 1'b0) && (txd === 1'b1);
    endtask

    task automatic test_reset();
        int bad_txd = 0, bad_busy = 0, bad_drop = 0;
        reset = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (1000) begin
            @(negedge clock);
            if (txd !== 1'b1)      bad_txd++;
            if (busy !== 1'b0)     bad_busy++;
            if (dropped !== 8'd0)  bad_drop++;
        end
        n_checks += 3;
        if (bad_txd !== 0)  begin n_fail++; $display("FAIL reset_txd: %0d cycles not idle-high, required 0", bad_txd); end
        if (bad_busy !== 0) begin n_fail++; $display("FAIL reset_busy: %0d cycles busy, required 0", bad_busy); end
        if (bad_drop !== 0) begin n_fail++; $display("FAIL reset_dropped: %0d cycles nonzero, required 0", bad_drop); end
    endtask

    task automatic test_basic_line();
        line_t      exp;
        logic [9:0] got_bits, want_bits;
        exp = model_line(13'h0A5, 16'hBEEF, 5'h13);
        run_line(13'h0A5, 16'hBEEF, 5'h13, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) got_bits[i] = cap_txd[i * CPB + CPB / 2];
        want_bits = 10'b1010100000;
        n_checks += 6;
        if (line_txt(cap_line()) != line_txt(exp)) begin
            n_fail++; $display("FAIL basic_text: got %s, required %s", line_txt(cap_line()), line_txt(exp));
        end
        if (wave_errors(exp) !== 0) begin
            n_fail++; $display("FAIL basic_wave: %0d bad cycles, required 0", wave_errors(exp));
        end
        if (got_bits !== want_bits) begin
            n_fail++; $display("FAIL basic_first_char: got %b, required %b (bit0 first on right)", got_bits, want_bits);
        end
        if (!lat_ok) begin n_fail++; $display("FAIL basic_latency: line started early (busy/txd changed on accepting edge)"); end
        if (busy_errors() !== 0 || !end_ok) begin
            n_fail++; $display("FAIL basic_busy_len: %0d gaps, end_ok=%0b, required 680 busy cycles", busy_errors(), end_ok);
        end
        if (dropped !== 8'(drop_model)) begin
            n_fail++; $display("FAIL basic_dropped: got %0d, required %0d", dropped, drop_model);
        end
    endtask

    task automatic test_snapshot();
        logic [12:0] p;
        logic [15:0] a;
        logic [4:0]  m;
        line_t       exp;
        for (int r = 0; r < 4; r++) begin
            if (r == 0) begin p = 13'h1FFF; a = 16'h0000; m = 5'h1F; end
            else begin p = 13'($urandom); a = 16'($urandom); m = 5'($urandom); end
            exp = model_line(p, a, m);
            run_line(p, a, m, 1'b1, 1'b0, 1'b0);
            n_checks += 2;
            if (line_txt(cap_line()) != line_txt(exp)) begin
                n_fail++; $display("FAIL snapshot_text[%0d]: got %s, required %s", r, line_txt(cap_line()), line_txt(exp));
            end
            if (wave_errors(exp) !== 0 || !end_ok) begin
                n_fail++; $display("FAIL snapshot_wave[%0d]: %0d bad cycles, end_ok=%0b", r, wave_errors(exp), end_ok);
            end
        end
    endtask

    // Start on the busy-falling edge is dropped; the next cycle's start begins a fresh line.
    task automatic test_back_to_back();
        logic [12:0] p;
        logic [15:0] a;
        logic [4:0]  m;
        line_t       exp;
        run_line(13'($urandom), 16'($urandom), 5'($urandom), 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (dropped !== 8'(drop_model)) begin
            n_fail++; $display("FAIL b2b_edge_dropped: got %0d, required %0d", dropped, drop_model);
        end
        p = 13'($urandom); a = 16'($urandom); m = 5'($urandom);
        exp = model_line(p, a, m);
        run_line(p, a, m, 1'b0, 1'b0, 1'b0);
        n_checks += 2;
        if (!lat_ok) begin n_fail++; $display("FAIL b2b_retrigger_latency: retriggered line not started on the expected cycle"); end
        if (line_txt(cap_line()) != line_txt(exp) || wave_errors(exp) !== 0) begin
            n_fail++; $display("FAIL b2b_retrigger_line: got %s, required %s", line_txt(cap_line()), line_txt(exp));
        end
    endtask

    task automatic test_busy_retrigger();
        logic [12:0] p;
        logic [15:0] a;
        logic [4:0]  m;
        line_t       exp;
        p = 13'($urandom); a = 16'($urandom); m = 5'($urandom);
        exp = model_line(p, a, m);
        run_line(p, a, m, 1'b0, 1'b1, 1'b0);
        n_checks += 3;
        if (line_txt(cap_line()) != line_txt(exp) || wave_errors(exp) !== 0) begin
            n_fail++; $display("FAIL spam_line: got %s, required %s", line_txt(cap_line()), line_txt(exp));
        end
        if (busy_errors() !== 0 || !end_ok) begin
            n_fail++; $display("FAIL spam_single_line: busy gaps %0d, end_ok=%0b", busy_errors(), end_ok);
        end
        if (dropped !== 8'(drop_model) || drop_model != 255) begin
            n_fail++; $display("FAIL spam_dropped: got %0d, model %0d, required 255", dropped, drop_model);
        end
    endtask

    task automatic test_reset_midline();
        int          residual = 0;
        logic [12:0] p;
        logic [15:0] a;
        logic [4:0]  m;
        line_t       exp;
        randomize_inputs();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        // land in character 5, bit 3
        repeat (5 * 10 * CPB + 3 * CPB + 2) @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midline_async: txd=%b busy=%b, required txd=1 busy=0", txd, busy);
        end
        drop_model = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (txd !== 1'b1 || busy !== 1'b0) residual++;
        end
        n_checks += 2;
        if (residual !== 0) begin n_fail++; $display("FAIL midline_residual: %0d non-idle cycles, required 0", residual); end
        if (dropped !== 8'd0) begin n_fail++; $display("FAIL midline_dropped_clear: got %0d, required 0", dropped); end
        p = 13'($urandom); a = 16'($urandom); m = 5'($urandom);
        exp = model_line(p, a, m);
        run_line(p, a, m, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (line_txt(cap_line()) != line_txt(exp) || wave_errors(exp) !== 0 || !lat_ok || !end_ok) begin
            n_fail++; $display("FAIL midline_new_line: got %s, required %s, lat_ok=%0b end_ok=%0b",
                               line_txt(cap_line()), line_txt(exp), lat_ok, end_ok);
        end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_snapshot();
        test_back_to_back();
        test_busy_retrigger();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
